// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: credit accumulation, price check, then the
// dispense and change-return handshakes, with cancel and inactivity refunds.
module vend_txn_ctrl #(
    parameter int CREDIT_W    = 8,
    parameter int NUM_PROD    = 4,
    parameter int MAX_CREDIT  = 200,
    parameter int TIMEOUT_CYC = 1000,
    localparam int ID_W       = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
    input  logic                         clk,
    input  logic                         reset_ni,
    input  logic                         coin_valid_i,
    input  logic [CREDIT_W-1:0]          coin_value_i,
    input  logic                         select_valid_i,
    input  logic [ID_W-1:0]              select_id_i,
    input  logic                         cancel_i,
    input  logic [NUM_PROD*CREDIT_W-1:0] price_table_i,
    output logic [CREDIT_W-1:0]          credit_o,
    output logic                         coin_reject_o,
    output logic                         insufficient_o,
    output logic                         disp_valid_o,
    output logic [ID_W-1:0]              disp_id_o,
    input  logic                         disp_ready_i,
    output logic                         chg_valid_o,
    output logic [CREDIT_W-1:0]          chg_amount_o,
    input  logic                         chg_ready_i,
    output logic                         busy_o
);

    // state    | meaning
    // IDLE     | no credit, waiting for the first coin
    // CREDIT   | accumulating credit, accepting select/cancel, timer running
    // DISPENSE | dispense request outstanding until disp_ready_i
    // CHANGE   | change-return request outstanding until chg_ready_i
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CREDIT   = 2'd1;
    localparam logic [1:0] ST_DISPENSE = 2'd2;
    localparam logic [1:0] ST_CHANGE   = 2'd3;

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CREDIT_W:0] MAX_WIDE  = (CREDIT_W + 1)'(MAX_CREDIT);

    logic [1:0]          state_q,        state_d;
    logic [CREDIT_W-1:0] credit_q,       credit_d;
    logic [CREDIT_W-1:0] chg_amount_q,   chg_amount_d;
    logic [ID_W-1:0]     disp_id_q,      disp_id_d;
    logic [TMR_W-1:0]    timer_q,        timer_d;
    logic                disp_valid_q,   disp_valid_d;
    logic                chg_valid_q,    chg_valid_d;
    logic                coin_reject_q,  coin_reject_d;
    logic                insufficient_q, insufficient_d;
    logic                busy_q,         busy_d;

    logic [CREDIT_W:0]   credit_sum;
    logic [CREDIT_W-1:0] price_sel;
    logic                coin_fits;
    logic                coin_first_ok;
    logic                sel_ok;
    logic                any_event;
    logic                timeout_hit;

    // Out-of-range ids fall through to a zero price, which is always refused.
    always_comb begin
        price_sel = '0;
        for (int k = 0; k < NUM_PROD; k++) begin
            if (int'(select_id_i) == k) begin
                price_sel = price_table_i[k*CREDIT_W +: CREDIT_W];
            end
        end
    end

    assign credit_sum    = {1'b0, credit_q} + {1'b0, coin_value_i};
    assign coin_fits     = (credit_sum <= MAX_WIDE);
    assign coin_first_ok = (coin_value_i != '0) && ({1'b0, coin_value_i} <= MAX_WIDE);
    assign sel_ok        = select_valid_i && (price_sel != '0) && (credit_q >= price_sel);
    assign any_event     = coin_valid_i || select_valid_i || cancel_i;
    assign timeout_hit   = !any_event && (timer_q == TMR_LAST);

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        chg_amount_d   = chg_amount_q;
        disp_id_d      = disp_id_q;
        disp_valid_d   = disp_valid_q;
        chg_valid_d    = chg_valid_q;
        timer_d        = '0;
        coin_reject_d  = 1'b0;
        insufficient_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (coin_valid_i) begin
                    if (coin_first_ok) begin
                        credit_d = coin_value_i;
                        state_d  = ST_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
                insufficient_d = select_valid_i;
            end

            ST_CREDIT: begin
                timer_d = any_event ? '0 : timer_q + TMR_W'(1);
                if (cancel_i || timeout_hit) begin
                    chg_amount_d  = credit_q;
                    credit_d      = '0;
                    chg_valid_d   = 1'b1;
                    state_d       = ST_CHANGE;
                    coin_reject_d = coin_valid_i;
                    timer_d       = '0;
                end else if (sel_ok) begin
                    credit_d      = credit_q - price_sel;
                    disp_id_d     = select_id_i;
                    disp_valid_d  = 1'b1;
                    state_d       = ST_DISPENSE;
                    coin_reject_d = coin_valid_i;
                    timer_d       = '0;
                end else begin
                    // A refused select does not block a coin in the same cycle.
                    insufficient_d = select_valid_i;
                    if (coin_valid_i) begin
                        if (coin_fits) begin
                            credit_d = credit_sum[CREDIT_W-1:0];
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                end
            end

            ST_DISPENSE: begin
                coin_reject_d = coin_valid_i;
                if (disp_ready_i) begin
                    disp_valid_d = 1'b0;
                    if (credit_q != '0) begin
                        chg_amount_d = credit_q;
                        credit_d     = '0;
                        chg_valid_d  = 1'b1;
                        state_d      = ST_CHANGE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_CHANGE: begin
                coin_reject_d = coin_valid_i;
                if (chg_ready_i) begin
                    chg_valid_d  = 1'b0;
                    chg_amount_d = '0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            chg_amount_q   <= '0;
            disp_id_q      <= '0;
            timer_q        <= '0;
            disp_valid_q   <= 1'b0;
            chg_valid_q    <= 1'b0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            chg_amount_q   <= chg_amount_d;
            disp_id_q      <= disp_id_d;
            timer_q        <= timer_d;
            disp_valid_q   <= disp_valid_d;
            chg_valid_q    <= chg_valid_d;
            coin_reject_q  <= coin_reject_d;
            insufficient_q <= insufficient_d;
            busy_q         <= busy_d;
        end
    end

    assign credit_o       = credit_q;
    assign coin_reject_o  = coin_reject_q;
    assign insufficient_o = insufficient_q;
    assign disp_valid_o   = disp_valid_q;
    assign disp_id_o      = disp_id_q;
    assign chg_valid_o    = chg_valid_q;
    assign chg_amount_o   = chg_amount_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Bench for vend_txn_ctrl: directed vector table, hand-written reset/timeout
// sequences, then random traffic against a transaction-level model.
module tb_vend_txn_ctrl;

    localparam int CW   = 8;
    localparam int NP   = 4;
    localparam int IW   = 2;
    localparam int MAXC = 200;
    localparam int TO   = 16;

    logic          clk = 1'b0;
    logic          reset_ni = 1'b0;
    logic          coin_valid_i = 1'b0;
    logic [CW-1:0] coin_value_i = '0;
    logic          select_valid_i = 1'b0;
    logic [IW-1:0] select_id_i = '0;
    logic          cancel_i = 1'b0;
    logic [NP*CW-1:0] price_table_i;
    logic [CW-1:0] credit_o;
    logic          coin_reject_o;
    logic          insufficient_o;
    logic          disp_valid_o;
    logic [IW-1:0] disp_id_o;
    logic          disp_ready_i = 1'b0;
    logic          chg_valid_o;
    logic [CW-1:0] chg_amount_o;
    logic          chg_ready_i = 1'b0;
    logic          busy_o;

    int price [NP] = '{0, 30, 50, 80};

    vend_txn_ctrl #(
        .CREDIT_W   (CW),
        .NUM_PROD   (NP),
        .MAX_CREDIT (MAXC),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk           (clk),
        .reset_ni      (reset_ni),
        .coin_valid_i  (coin_valid_i),
        .coin_value_i  (coin_value_i),
        .select_valid_i(select_valid_i),
        .select_id_i   (select_id_i),
        .cancel_i      (cancel_i),
        .price_table_i (price_table_i),
        .credit_o      (credit_o),
        .coin_reject_o (coin_reject_o),
        .insufficient_o(insufficient_o),
        .disp_valid_o  (disp_valid_o),
        .disp_id_o     (disp_id_o),
        .disp_ready_i  (disp_ready_i),
        .chg_valid_o   (chg_valid_o),
        .chg_amount_o  (chg_amount_o),
        .chg_ready_i   (chg_ready_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NP; k++) price_table_i[k*CW +: CW] = CW'(price[k]);
    end

    typedef struct {
        bit cv; int cval; bit sv; int sid; bit can; bit dr; bit cr;
        int e_credit; bit e_rej; bit e_ins; bit e_dv; int e_id; bit e_cgv; int e_amt; bit e_busy;
    } vec_t;

    vec_t vecs[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(bit cv, int cval, bit sv, int sid, bit can, bit dr, bit cr,
                                int ec, bit er, bit ei, bit edv, int eid, bit ecg, int eamt, bit eb);
        vec_t v;
        v.cv = cv; v.cval = cval; v.sv = sv; v.sid = sid; v.can = can; v.dr = dr; v.cr = cr;
        v.e_credit = ec; v.e_rej = er; v.e_ins = ei; v.e_dv = edv; v.e_id = eid;
        v.e_cgv = ecg; v.e_amt = eamt; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(string tag, int ec, bit er, bit ei, bit edv, int eid,
                              bit ecg, int eamt, bit eb);
        chk({tag, ".credit"},  int'(credit_o), ec);
        chk({tag, ".reject"},  int'(coin_reject_o), int'(er));
        chk({tag, ".insuff"},  int'(insufficient_o), int'(ei));
        chk({tag, ".dvalid"},  int'(disp_valid_o), int'(edv));
        if (edv) chk({tag, ".did"}, int'(disp_id_o), eid);
        chk({tag, ".cvalid"},  int'(chg_valid_o), int'(ecg));
        chk({tag, ".camount"}, int'(chg_amount_o), eamt);
        chk({tag, ".busy"},    int'(busy_o), int'(eb));
    endtask

    task automatic drive(bit cv, int cval, bit sv, int sid, bit can, bit dr, bit cr);
        coin_valid_i   = cv;
        coin_value_i   = CW'(cval);
        select_valid_i = sv;
        select_id_i    = IW'(sid);
        cancel_i       = can;
        disp_ready_i   = dr;
        chg_ready_i    = cr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: a sale is a session holding credit, an
    // outstanding dispense order, and an outstanding refund amount.
    int m_credit, m_id, m_refund, m_idle;
    bit m_session, m_order, m_rej, m_ins;

    task automatic model_reset();
        m_credit = 0; m_id = 0; m_refund = 0; m_idle = 0;
        m_session = 0; m_order = 0; m_rej = 0; m_ins = 0;
    endtask

    task automatic model_step(bit cv, int cval, bit sv, int sid, bit can, bit dr, bit cr);
        bit ev, sold;
        int p;
        m_rej = 0; m_ins = 0;
        ev = cv || sv || can;
        if (m_order) begin
            m_rej = cv;
            if (dr) begin
                m_order = 0;
                m_refund = m_credit;
                m_credit = 0;
            end
        end else if (m_refund > 0) begin
            m_rej = cv;
            if (cr) m_refund = 0;
        end else if (!m_session) begin
            if (cv) begin
                if (cval > 0 && cval <= MAXC) begin
                    m_credit = cval; m_session = 1; m_idle = 0;
                end else m_rej = 1;
            end
            m_ins = sv;
        end else begin
            if (can || (!ev && m_idle == TO - 1)) begin
                m_refund = m_credit; m_credit = 0; m_session = 0; m_rej = cv;
            end else begin
                sold = 0;
                if (sv) begin
                    p = (sid < NP) ? price[sid] : 0;
                    if (p != 0 && m_credit >= p) begin
                        m_credit -= p; m_order = 1; m_id = sid; m_session = 0; sold = 1;
                    end else m_ins = 1;
                end
                if (cv) begin
                    if (sold) m_rej = 1;
                    else if (m_credit + cval <= MAXC) m_credit += cval;
                    else m_rej = 1;
                end
            end
            m_idle = ev ? 0 : m_idle + 1;
        end
    endtask

    initial begin
        //            cv cval sv sid can dr cr | credit rej ins dv id cgv amt busy
        // exact price on product 2
        vecs.push_back(mk(1, 20, 0, 0, 0, 0, 0,  20, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 20, 0, 0, 0, 0, 0,  40, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10, 0, 0, 0, 0, 0,  50, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 1, 2, 0, 0, 0,   0, 0, 0, 1, 2, 0, 0, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 2, 0, 0, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 2, 0, 0, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 2, 0, 0, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0));
        // overpay on product 1
        vecs.push_back(mk(1, 50, 0, 0, 0, 0, 0,  50, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 1, 1, 0, 0, 0,  20, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 20, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 20, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0));
        // saturation, then select beats a same-cycle coin
        vecs.push_back(mk(1, 100, 0, 0, 0, 0, 0, 100, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 100, 0, 0, 0, 0, 0, 200, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10, 0, 0, 0, 0, 0, 200, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10, 1, 3, 0, 0, 0, 120, 1, 0, 1, 3, 0, 0, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 120, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0));
        // insufficient credit, then cancel
        vecs.push_back(mk(1, 40, 0, 0, 0, 0, 0,  40, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 1, 3, 0, 0, 0,  40, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 1, 40, 1));
        vecs.push_back(mk(1,  5, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 40, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0));
        // idle-state corners and zero-price product
        vecs.push_back(mk(0,  0, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 201, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 200, 0, 0, 0, 0, 0, 200, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 1, 0, 0, 0, 0, 200, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1,  5, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0, 1, 200, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0));

        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cv, vecs[i].cval, vecs[i].sv, vecs[i].sid, vecs[i].can,
                  vecs[i].dr, vecs[i].cr);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_credit, vecs[i].e_rej, vecs[i].e_ins,
                       vecs[i].e_dv, vecs[i].e_id, vecs[i].e_cgv, vecs[i].e_amt, vecs[i].e_busy);
        end

        // inactivity refund
        drive(1, 25, 0, 0, 0, 0, 0);
        tick();
        check_outs("to_coin", 25, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k < TO; k++) begin
            tick();
            chk($sformatf("to_wait%0d.cvalid", k), int'(chg_valid_o), 0);
            chk($sformatf("to_wait%0d.credit", k), int'(credit_o), 25);
        end
        tick();
        check_outs("to_fire", 0, 0, 0, 0, 0, 1, 25, 1);
        drive(1, 7, 0, 0, 0, 0, 0);
        tick();
        check_outs("to_coin_in_chg", 0, 1, 0, 0, 0, 1, 25, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        check_outs("to_done", 0, 0, 0, 0, 0, 0, 0, 0);

        // reset while a dispense request is outstanding
        drive(1, 50, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 1, 0, 0, 0);
        tick();
        check_outs("rst_pre", 20, 0, 0, 1, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        reset_ni = 1'b0;
        #1;
        check_outs("rst_async", 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_ni = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 1);
        tick();
        check_outs("rst_post", 0, 0, 0, 0, 0, 0, 0, 0);

        // random traffic against the model
        drive(0, 0, 0, 0, 0, 0, 0);
        reset_ni = 1'b0;
        #3;
        reset_ni = 1'b1;
        model_reset();
        for (int i = 0; i < 4000; i++) begin
            bit quiet, cv, sv, can, dr, cr;
            int cval, sid, r;
            quiet = ((i / 250) % 2) == 1;
            cv  = $urandom_range(0, 99) < (quiet ? 1 : 25);
            r   = $urandom_range(0, 9);
            cval = (r == 0) ? 0 : (r == 1) ? $urandom_range(201, 255) : $urandom_range(1, 120);
            sv  = $urandom_range(0, 99) < (quiet ? 1 : 15);
            sid = $urandom_range(0, NP - 1);
            can = $urandom_range(0, 99) < (quiet ? 0 : 4);
            dr  = $urandom_range(0, 1) == 1;
            cr  = $urandom_range(0, 1) == 1;
            drive(cv, cval, sv, sid, can, dr, cr);
            model_step(cv, cval, sv, sid, can, dr, cr);
            tick();
            check_outs($sformatf("rnd%0d", i), m_credit, m_rej, m_ins, m_order, m_id,
                       m_refund > 0, m_refund, m_order || (m_refund > 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_txn_ctrl.md
Name: vend_txn_ctrl

Overview:
Transaction sequencer for the vending datapath. Accumulates credit from validated coin events and checks product selections against a price table. It then sequences the dispense handshake followed by the change-return handshake, and handles cancel and inactivity refunds. It sits between the coin/keypad front-end (debounced pulse sources) and the dispenser/change-hopper drivers.

Parameters:
CREDIT_W, 8, width of credit, coin value, price and change buses
NUM_PROD, 4, number of products; select_id_i width is $clog2(NUM_PROD)
MAX_CREDIT, 200, credit ceiling; a coin that would exceed it is rejected
TIMEOUT_CYC, 1000, idle cycles in CREDIT before an automatic refund

Ports:
clk  in  1  system clock
reset_ni  in  1  asynchronous active-low reset
coin_valid_i  in  1  one-cycle pulse: coin accepted by the front-end
coin_value_i  in  CREDIT_W  coin value, qualified by coin_valid_i
select_valid_i  in  1  one-cycle pulse: product selected
select_id_i  in  $clog2(NUM_PROD)  selected product index
cancel_i  in  1  one-cycle pulse: refund request
price_table_i  in  NUM_PROD*CREDIT_W  flat price table; product k at bits [k*CREDIT_W +: CREDIT_W]; static during a transaction
credit_o  out  CREDIT_W  current credit, registered
coin_reject_o  out  1  one-cycle pulse: coin refused
insufficient_o  out  1  one-cycle pulse: selection refused for insufficient credit
disp_valid_o  out  1  dispense request
disp_id_o  out  $clog2(NUM_PROD)  product to dispense, held while disp_valid_o is high
disp_ready_i  in  1  dispenser accepts the request
chg_valid_o  out  1  change-return request
chg_amount_o  out  CREDIT_W  amount to return, held while chg_valid_o is high
chg_ready_i  in  1  hopper accepts the request
busy_o  out  1  high in DISPENSE or CHANGE

Behaviour:
- Reset (asynchronous, reset_ni=0): state IDLE. credit_o, chg_amount_o, disp_id_o, the timeout counter and all valid/pulse outputs are 0. Reset mid-handshake drops every request immediately, with no completion.
- All outputs are registered. Event pulses (coin_reject_o, insufficient_o) appear the cycle after the causing input.
- States: IDLE, CREDIT, DISPENSE, CHANGE.
- IDLE:
  - Coin with value>0 and value<=MAX_CREDIT -> credit=value, go to CREDIT.
  - Coin with value 0 or value>MAX_CREDIT -> reject, stay IDLE.
  - select_valid_i -> insufficient_o pulse.
  - cancel_i -> ignored.
- CREDIT:
  - Per-cycle input priority: cancel > select > coin. A coin arriving in the same cycle as an accepted cancel or select gets coin_reject_o.
  - Coin: if credit+value (computed CREDIT_W+1 wide) <= MAX_CREDIT, credit += value. Otherwise reject; credit unchanged.
  - Select id: if id >= NUM_PROD or price[id]==0 -> insufficient_o pulse.
  - If credit >= price[id]: credit -= price[id], latch disp_id_o=id, go to DISPENSE.
  - If credit < price[id]: insufficient_o pulse, stay CREDIT.
  - Cancel: chg_amount_o=credit, credit=0, go to CHANGE.
  - Timeout: counter clears on any coin, select or cancel event and otherwise increments. When it reaches TIMEOUT_CYC-1, behave as cancel.
- DISPENSE:
  - disp_valid_o=1 until a cycle with disp_ready_i=1. That cycle is the transfer; disp_valid_o drops the next cycle.
  - After the transfer: if credit>0, chg_amount_o=credit, credit=0, go to CHANGE. Otherwise go to IDLE.
- CHANGE:
  - chg_valid_o=1 until chg_ready_i=1. After the transfer, go to IDLE with chg_amount_o=0.
- In DISPENSE and CHANGE: coins are rejected; select and cancel are ignored.
- Ready asserted before valid has no effect. Ready held high gives a transfer in the first valid cycle.
- Latency:
  - Exact-price select to disp_valid_o: 1 cycle.
  - Dispense transfer to chg_valid_o (when change is due): 1 cycle.
- credit_o never exceeds MAX_CREDIT and never underflows.

Test Plan:
- Reset mid-DISPENSE with disp_valid_o=1: assert reset_ni=0 -> disp_valid_o=0 and credit_o=0 immediately; IDLE after release.
- Exact price, price[2]=50: coins 20, 20, 10, then select 2 -> credit 50 then 0. disp_valid_o with id 2 the cycle after select. disp_ready_i held low 3 cycles then high -> single transfer, no chg_valid_o, back to IDLE.
- Overpay, price[1]=30: coins 50, then select 1 -> dispense id 1, then chg_valid_o with chg_amount_o=20. chg_ready_i pulse -> IDLE, credit_o=0.
- Saturation and priority, MAX_CREDIT=200: coins 100, 100, 10 -> third coin gets coin_reject_o, credit 200. Then select and coin in the same cycle -> coin rejected, select processed.
- Insufficient credit, price[3]=80: credit 40, select 3 -> insufficient_o pulse, stay CREDIT, credit 40. Then cancel -> chg_amount_o=40.
- Timeout, TIMEOUT_CYC=16: single coin 25, then no activity -> CHANGE entered 16 cycles after the coin with chg_amount_o=25. A coin during CHANGE -> coin_reject_o.
